// File: rtl/vn_decision_stage.sv
// Serial posterior-LLR hard decision and parity-check syndrome stage for the LDPC decoder output.
// Optional macro VN_DECISION_SOFT_OUT_EN adds a saturated soft posterior output.
module vn_decision_stage #(
    parameter int N_V  = 44,
    parameter int N_C  = 12,
    parameter int E    = 147,
    parameter int N_FP = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:N_V-1][0:E-1]         adj_matrix_out,
    input  logic [0:N_C-1][0:N_V-1]       h_matrix,
    input  logic [0:N_V-1][N_FP-1:0]      llr,
    input  logic [0:E-1][N_FP-1:0]        prev_proc_elem,
    output logic                          busy,
    output logic                          done,
    output logic [0:N_V-1]                codeword,
`ifdef VN_DECISION_SOFT_OUT_EN
    output logic [0:N_V-1][N_FP-1:0]      posterior,
`endif
    output logic                          syndrome_ok
);

    localparam int SUM_W = N_FP + $clog2(E + 1) + 1;
    localparam int VW    = (N_V > 1) ? $clog2(N_V) : 1;
    localparam int CW    = (N_C > 1) ? $clog2(N_C) : 1;
    localparam logic signed [SUM_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, ACCUM, SYND, DONE} state_t;

    state_t state_q, state_d;

    logic [0:N_V-1][0:E-1]    snap_adj;
    logic [0:N_C-1][0:N_V-1]  snap_h;
    logic [0:N_V-1][N_FP-1:0] snap_llr;
    logic [0:E-1][N_FP-1:0]   snap_msg;

    logic [VW-1:0]            v_cnt;
    logic [CW-1:0]            c_cnt;
    logic                     fail;
    logic                     v_last, c_last, parity, capture;
    logic signed [SUM_W-1:0]  sum;

`ifdef VN_DECISION_SOFT_OUT_EN
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 <<< (N_FP - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

    // Symmetric clamp so the soft output never carries the asymmetric -2^(N_FP-1)
    function automatic logic signed [N_FP-1:0] sat_sym(input logic signed [SUM_W-1:0] x);
        if (x > SAT_HI)
            return SAT_HI[N_FP-1:0];
        else if (x < SAT_LO)
            return SAT_LO[N_FP-1:0];
        else
            return x[N_FP-1:0];
    endfunction
`endif

    assign v_last  = (v_cnt == VW'(N_V - 1));
    assign c_last  = (c_cnt == CW'(N_C - 1));
    assign capture = (state_q == IDLE) && start;
    assign parity  = ^(snap_h[c_cnt] & codeword);

    always_comb begin
        sum = SUM_W'($signed(snap_llr[v_cnt]));
        for (int e = 0; e < E; e++) begin
            if (snap_adj[v_cnt][e])
                sum = sum + SUM_W'($signed(snap_msg[e]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (v_last) state_d = SYND;
            end
            SYND: begin
                busy = 1'b1;
                if (c_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, accumulate/decide, then syndrome; results hold until the next capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_adj    <= '0;
            snap_h      <= '0;
            snap_llr    <= '0;
            snap_msg    <= '0;
            v_cnt       <= '0;
            c_cnt       <= '0;
            fail        <= 1'b0;
            codeword    <= '0;
            syndrome_ok <= 1'b0;
`ifdef VN_DECISION_SOFT_OUT_EN
            posterior   <= '0;
`endif
        end else begin
            if (capture) begin
                snap_adj    <= adj_matrix_out;
                snap_h      <= h_matrix;
                snap_llr    <= llr;
                snap_msg    <= prev_proc_elem;
                v_cnt       <= '0;
                c_cnt       <= '0;
                fail        <= 1'b0;
                syndrome_ok <= 1'b0;
            end
            if (state_q == ACCUM) begin
                codeword[v_cnt] <= (sum < ZERO);
`ifdef VN_DECISION_SOFT_OUT_EN
                posterior[v_cnt] <= sat_sym(sum);
`endif
                if (!v_last)
                    v_cnt <= v_cnt + VW'(1);
            end
            if (state_q == SYND) begin
                fail <= fail | parity;
                if (c_last)
                    syndrome_ok <= ~(fail | parity);
                else
                    c_cnt <= c_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vn_decision_stage.sv
// Self-checking bench for vn_decision_stage: directed and random frames against a behavioural model.
module tb_vn_decision_stage;

    localparam int N_V  = 44;
    localparam int N_C  = 12;
    localparam int E    = 147;
    localparam int N_FP = 8;
    localparam int LAT  = N_V + N_C + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [0:N_V-1][0:E-1]    adj;
    logic [0:N_C-1][0:N_V-1]  h;
    logic [0:N_V-1][N_FP-1:0] llr_i;
    logic [0:E-1][N_FP-1:0]   msg;
    logic                     busy, done, syndrome_ok;
    logic [0:N_V-1]           codeword;
`ifdef VN_DECISION_SOFT_OUT_EN
    logic [0:N_V-1][N_FP-1:0] posterior;
`endif

    logic [0:N_V-1]           exp_cw;
    logic                     exp_ok;
    logic [0:N_V-1][N_FP-1:0] exp_post;

    int checks = 0;
    int errors = 0;

    vn_decision_stage #(.N_V(N_V), .N_C(N_C), .E(E), .N_FP(N_FP)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .adj_matrix_out (adj),
        .h_matrix       (h),
        .llr            (llr_i),
        .prev_proc_elem (msg),
        .busy           (busy),
        .done           (done),
        .codeword       (codeword),
`ifdef VN_DECISION_SOFT_OUT_EN
        .posterior      (posterior),
`endif
        .syndrome_ok    (syndrome_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: posterior = llr + sum of messages on the variable's edges, sign decision,
    // then even parity required on every check row.
    function automatic void model();
        int lim;
        lim = (1 << (N_FP - 1)) - 1;
        for (int v = 0; v < N_V; v++) begin
            int s;
            s = $signed(llr_i[v]);
            for (int e = 0; e < E; e++)
                if (adj[v][e]) s += $signed(msg[e]);
            exp_cw[v] = (s < 0);
            if (s > lim) s = lim;
            if (s < -lim) s = -lim;
            exp_post[v] = N_FP'(s);
        end
        exp_ok = 1'b1;
        for (int c = 0; c < N_C; c++) begin
            logic p;
            p = 1'b0;
            for (int v = 0; v < N_V; v++) p ^= (h[c][v] & exp_cw[v]);
            if (p) exp_ok = 1'b0;
        end
    endfunction

    task automatic rand_graph();
        adj = '0;
        for (int e = 0; e < E; e++) adj[$urandom_range(N_V - 1, 0)][e] = 1'b1;
        for (int c = 0; c < N_C; c++)
            for (int v = 0; v < N_V; v++) h[c][v] = ($urandom_range(3, 0) == 0);
    endtask

    task automatic rand_vals();
        for (int v = 0; v < N_V; v++) llr_i[v] = N_FP'($urandom);
        for (int e = 0; e < E; e++) msg[e] = N_FP'($urandom);
    endtask

    // mode 0: normal frame, 1: second start with new inputs mid-frame, 2: reset mid-frame
    task automatic run_frame(input string tag, input int mode);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        model();
        start = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                check({tag, "_sok_clear"}, 512'(syndrome_ok), 512'(0));
            end
            if (mode == 1 && k == 10) begin
                rand_graph();
                rand_vals();
                start = 1'b1;
            end
            if (mode == 1 && k == 11) start = 1'b0;
            if (mode == 2 && k == 30) begin
                rst = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 512'(busy), 512'(0));
                check({tag, "_rst_done"}, 512'(done), 512'(0));
                check({tag, "_rst_cw"}, 512'(codeword), 512'(0));
                check({tag, "_rst_sok"}, 512'(syndrome_ok), 512'(0));
                repeat (2) begin
                    @(posedge clk); #1;
                    done_cnt += int'(done);
                end
                check({tag, "_rst_no_done"}, 512'(done_cnt), 512'(0));
                rst = 1'b1;
                return;
            end
            if (k < LAT) begin
                busy_cnt += int'(busy);
                done_cnt += int'(done);
            end
        end
        check({tag, "_done"}, 512'(done), 512'(1));
        check({tag, "_busy_low"}, 512'(busy), 512'(0));
        check({tag, "_busy_cycles"}, 512'(busy_cnt), 512'(LAT - 1));
        check({tag, "_early_done"}, 512'(done_cnt), 512'(0));
        check({tag, "_codeword"}, 512'(codeword), 512'(exp_cw));
        check({tag, "_syndrome_ok"}, 512'(syndrome_ok), 512'(exp_ok));
`ifdef VN_DECISION_SOFT_OUT_EN
        check({tag, "_posterior"}, 512'(posterior), 512'(exp_post));
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 512'(done), 512'(0));
        check({tag, "_cw_hold"}, 512'(codeword), 512'(exp_cw));
        check({tag, "_sok_hold"}, 512'(syndrome_ok), 512'(exp_ok));
        if (mode == 1) begin
            done_cnt = 0;
            repeat (LAT + 3) begin
                @(posedge clk); #1;
                done_cnt += int'(done);
            end
            check({tag, "_no_second_done"}, 512'(done_cnt), 512'(0));
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        adj   = '0;
        h     = '0;
        llr_i = '0;
        msg   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 512'(busy), 512'(0));
        check("reset_done", 512'(done), 512'(0));
        check("reset_cw", 512'(codeword), 512'(0));
        check("reset_sok", 512'(syndrome_ok), 512'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // All-positive channel, zero messages
        rand_graph();
        for (int v = 0; v < N_V; v++) llr_i[v] = N_FP'(20);
        msg = '0;
        run_frame("basic", 0);
        check("basic_cw_zero", 512'(codeword), 512'(0));
        check("basic_sok_one", 512'(syndrome_ok), 512'(1));

        // Single flipped bit seen by checks 2 and 7
        for (int c = 0; c < N_C; c++) h[c][5] = 1'b0;
        h[2][5] = 1'b1;
        h[7][5] = 1'b1;
        llr_i[5] = N_FP'(-30);
        run_frame("flip", 0);
        check("flip_bit5", 512'(codeword[5]), 512'(1));
        check("flip_sok_zero", 512'(syndrome_ok), 512'(0));

        // Message correction (-10+3*5) and exact tie (0-5+5)
        adj = '0;
        for (int e = 5; e < E; e++) adj[10][e] = 1'b1;
        for (int e = 0; e < 3; e++) adj[3][e] = 1'b1;
        adj[4][3] = 1'b1;
        adj[4][4] = 1'b1;
        msg = '0;
        for (int e = 0; e < 3; e++) msg[e] = N_FP'(5);
        msg[3] = N_FP'(-5);
        msg[4] = N_FP'(5);
        for (int v = 0; v < N_V; v++) llr_i[v] = N_FP'(20);
        llr_i[3] = N_FP'(-10);
        llr_i[4] = '0;
        run_frame("tie", 0);
        check("tie_bit3", 512'(codeword[3]), 512'(0));
        check("tie_bit4", 512'(codeword[4]), 512'(0));

        for (int i = 0; i < 4; i++) begin
            rand_graph();
            rand_vals();
            run_frame($sformatf("rand%0d", i), 0);
        end

        rand_graph();
        rand_vals();
        run_frame("busy_start", 1);

        rand_graph();
        rand_vals();
        run_frame("midreset", 2);
        @(posedge clk); #1;
        rand_graph();
        rand_vals();
        run_frame("after_reset", 0);

        // Saturation corners of the posterior
        adj = '0;
        for (int e = 3; e < E; e++) adj[10][e] = 1'b1;
        adj[0][0] = 1'b1;
        adj[0][1] = 1'b1;
        adj[1][2] = 1'b1;
        msg = '0;
        msg[0] = N_FP'(100);
        msg[1] = N_FP'(100);
        msg[2] = N_FP'(-50);
        for (int v = 0; v < N_V; v++) llr_i[v] = N_FP'(20);
        llr_i[0] = N_FP'(120);
        llr_i[1] = N_FP'(-128);
        run_frame("sat", 0);
        check("sat_bit0", 512'(codeword[0]), 512'(0));
        check("sat_bit1", 512'(codeword[1]), 512'(1));
`ifdef VN_DECISION_SOFT_OUT_EN
        check("sat_post0", 512'(posterior[0]), 512'(8'h7F));
        check("sat_post1", 512'(posterior[1]), 512'(8'h81));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
